// File: rtl/byte_to_bcd_pkg.sv
// bcd_pkg: shared widths, working-word type and add-3 helper for the byte-to-BCD pipeline.
package bcd_pkg;
  localparam int BIN_W            = 8;
  localparam int DIGITS           = 3;
  localparam int BCD_W            = 12;
  localparam int N_SHIFTS         = 8;
  localparam int SHIFTS_PER_STAGE = 2;
  localparam int STAGES           = 4;
  localparam int WORD_W           = BCD_W + BIN_W;
  typedef logic [WORD_W-1:0] word_t;
  function automatic logic [3:0] add3(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction
endpackage

// File: rtl/byte_to_bcd_dabble_step.sv
// dabble_step: one double-dabble iteration on {bcd, bin}: add 3 to every nibble >= 5, then shift left.
module dabble_step
  import bcd_pkg::*;
(
  input  word_t word_i,
  output word_t word_o
);
  word_t adj;
  always_comb begin
    adj = word_i;
    for (int d = 0; d < DIGITS; d++) adj[BIN_W+4*d +: 4] = add3(word_i[BIN_W+4*d +: 4]);
  end
  assign word_o = adj << 1;
endmodule

// File: rtl/byte_to_bcd.sv
// byte_to_bcd: 4-stage pipelined double-dabble converter, 8-bit binary to 3-digit packed BCD.
module byte_to_bcd
  import bcd_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [BIN_W-1:0] byte_i,
  input  logic             in_valid_i,
  output logic [BCD_W-1:0] bcd_o,
  output logic             out_valid_o
);
  word_t src_w   [N_SHIFTS];
  word_t dst_w   [N_SHIFTS];
  word_t stage_d [STAGES];
  word_t stage_q [STAGES];
  logic [STAGES-1:0] valid_d, valid_q;
  genvar k, s;
  // Each stage boundary restarts the combinational chain from the previous register.
  for (k = 0; k < N_SHIFTS; k++) begin : g_step
    if (k == 0) begin : g_in
      assign src_w[k] = {{BCD_W{1'b0}}, byte_i};
    end else if (k % SHIFTS_PER_STAGE == 0) begin : g_reg
      assign src_w[k] = stage_q[k/SHIFTS_PER_STAGE-1];
    end else begin : g_chain
      assign src_w[k] = dst_w[k-1];
    end
    dabble_step u_step (.word_i(src_w[k]), .word_o(dst_w[k]));
  end
  for (s = 0; s < STAGES; s++) begin : g_stage
    assign stage_d[s] = dst_w[s*SHIFTS_PER_STAGE+SHIFTS_PER_STAGE-1];
  end
  assign valid_d = {valid_q[STAGES-2:0], in_valid_i};
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      stage_q <= '{default: '0};
      valid_q <= '0;
    end else begin
      stage_q <= stage_d;
      valid_q <= valid_d;
    end
  assign bcd_o       = stage_q[STAGES-1][WORD_W-1 -: BCD_W];
  assign out_valid_o = valid_q[STAGES-1];
endmodule

// File: tb/tb_byte_to_bcd.sv
// tb_byte_to_bcd: directed checks of latency, boundaries, full sweep, valid gating and reset for byte_to_bcd.
module tb_byte_to_bcd;
  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  din;
  logic        vin;
  logic [11:0] bcd;
  logic        vout;
  int total = 0;
  int bad = 0;
  byte_to_bcd dut (
    .clk(clk), .rst(rst), .byte_i(din), .in_valid_i(vin),
    .bcd_o(bcd), .out_valid_o(vout)
  );
  always #5 clk = ~clk;
  function automatic logic [11:0] to_bcd(input int n);
    return {4'(n / 100), 4'((n / 10) % 10), 4'(n % 10)};
  endfunction
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic chk_bcd(input string tag, input logic [11:0] exp);
    total++;
    assert (bcd === exp) else begin
      bad++;
      $error("FAIL %s bcd observed=%h expected=%h", tag, bcd, exp);
    end
  endtask
  task automatic chk_v(input string tag, input logic exp);
    total++;
    assert (vout === exp) else begin
      bad++;
      $error("FAIL %s out_valid observed=%b expected=%b", tag, vout, exp);
    end
  endtask
  logic [7:0]  bnd_in  [6] = '{8'd0, 8'd9, 8'd10, 8'd99, 8'd100, 8'd255};
  logic [11:0] bnd_exp [6] = '{12'h000, 12'h009, 12'h010, 12'h099, 12'h100, 12'h255};
  logic [7:0]  gt_in   [5] = '{8'd13, 8'd77, 8'd128, 8'd201, 8'd42};
  logic        gt_v    [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
  logic [11:0] gt_exp  [5] = '{12'h013, 12'h077, 12'h128, 12'h201, 12'h042};
  initial begin
    rst = 1'b1; din = 8'd200; vin = 1'b1;
    @(negedge clk);
    chk_bcd("reset_hold0", 12'h000); chk_v("reset_hold0", 1'b0);
    tick(); tick(); tick();
    chk_bcd("reset_hold1", 12'h000); chk_v("reset_hold1", 1'b0);
    rst = 1'b0;
    tick(); tick(); tick();
    chk_v("first_not_yet", 1'b0);
    tick();
    chk_bcd("after_reset_200", 12'h200); chk_v("after_reset_200", 1'b1);
    for (int t = 0; t < 9; t++) begin
      din = (t < 6) ? bnd_in[t] : 8'd0;
      vin = (t < 6);
      tick();
      if (t >= 3) begin
        chk_bcd($sformatf("boundary_%0d", bnd_in[t-3]), bnd_exp[t-3]);
        chk_v("boundary_v", 1'b1);
      end
    end
    for (int i = 0; i < 260; i++) begin
      din = 8'(i); vin = 1'b1;
      tick();
      if (i >= 3) begin
        chk_bcd($sformatf("sweep_%0d", (i - 3) % 256), to_bcd((i - 3) % 256));
        chk_v("sweep_v", 1'b1);
      end
    end
    for (int t = 0; t < 8; t++) begin
      din = (t < 5) ? gt_in[t] : 8'd0;
      vin = (t < 5) ? gt_v[t] : 1'b0;
      tick();
      if (t >= 3) begin
        chk_v($sformatf("gate_%0d", t - 3), gt_v[t-3]);
        if (gt_v[t-3]) chk_bcd($sformatf("gate_%0d", t - 3), gt_exp[t-3]);
      end
    end
    din = 8'd50; vin = 1'b1; tick();
    din = 8'd51; tick();
    din = 8'd52; tick();
    din = 8'd0; vin = 1'b0; tick();
    rst = 1'b1;
    #1;
    chk_bcd("async_clear", 12'h000); chk_v("async_clear", 1'b0);
    @(negedge clk);
    rst = 1'b0;
    for (int t = 0; t < 5; t++) begin
      tick();
      chk_v($sformatf("flushed_%0d", t), 1'b0);
    end
    din = 8'd77; vin = 1'b1; tick();
    din = 8'd0; vin = 1'b0;
    tick(); tick();
    chk_v("post_rst_pending", 1'b0);
    tick();
    chk_bcd("post_rst_77", 12'h077); chk_v("post_rst_77", 1'b1);
    tick();
    chk_v("post_rst_after", 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/byte_to_bcd.md
# byte_to_bcd

Pipelined binary-to-BCD converter: takes an unsigned 8-bit value each clock and produces its three-digit packed BCD equivalent (hundreds, tens, ones) a fixed number of cycles later. It sits between the audio controller's byte-valued status/level registers and the display drivers, so a 7-segment driver can show 000–255 directly. Throughput is one conversion per clock with no back-pressure.

## Interface
Parameters:
- none. Widths are fixed by the shared package constants.

Ports (clock and reset first):
- clk  input  1  rising-edge system clock; one clock domain.
- rst  input  1  reset, asynchronous and active-high.
- byte  input  8  unsigned binary value, 0–255, sampled every rising edge.
- in_valid  input  1  qualifies byte; carried alongside the data through the pipeline.
- BCD  output  12  packed BCD: [11:8] hundreds, [7:4] tens, [3:0] ones.
- out_valid  output  1  in_valid delayed to align with BCD.

## Operation
- Algorithm: double-dabble (shift-and-add-3), 8 shift iterations over a 20-bit working register ({12-bit BCD, 8-bit binary}).
- Each iteration: for every BCD nibble ≥ 5, add 3 to that nibble; then shift the whole working register left by one.
- Iterations split over 4 register stages, 2 iterations per stage. Stage 1 operates directly on byte (no separate input register).
- Datapath registers load every cycle, independent of in_valid; out_valid alone qualifies BCD.
- Hundreds digit is always 0–2; tens and ones are always 0–9. No out-of-range or overflow condition exists, and none is flagged.
- No stall or enable. Every input sample produces exactly one output 4 cycles later.

## Timing
- Latency: byte/in_valid sampled at rising edge N appear on BCD/out_valid immediately after edge N+3. That is 4 edges, counting the sampling edge.
- Back-to-back: a new value every cycle yields a new result every cycle, in order, with no bubbles.
- Reset: while rst is high, all stage registers clear asynchronously. BCD = 12'h000, out_valid = 0.
- Reset mid-operation: in-flight samples are discarded. After rst deasserts, out_valid stays 0 until the first valid sample taken after reset has traversed 4 edges.
- The first sampling edge after deassertion behaves like edge N above.
- Outputs are driven only from registers; no combinational path from byte to BCD.

## Structure
- Package bcd_pkg: BIN_W = 8, DIGITS = 3, BCD_W = 12, N_SHIFTS = 8, SHIFTS_PER_STAGE = 2, STAGES = 4.
- Sub-module dabble_step: combinational, one iteration (conditional add-3 per nibble, then shift left 1) on the 20-bit working word.
  - The top level instantiates it 8 times, in pairs between pipeline registers.
- Top level holds the 4 stage registers, the valid shift chain, and the async reset.

## Test plan
- Reset: assert rst with in_valid = 1 and byte = 8'd200. Required: BCD = 12'h000 and out_valid = 0 throughout reset. Deassert rst; after 4 edges, BCD = 12'h200 and out_valid = 1.
- Boundaries: byte = 0, 9, 10, 99, 100, 255, one per cycle. Required: BCD = 12'h000, 12'h009, 12'h010, 12'h099, 12'h100, 12'h255, each 4 edges after its sample, in consecutive cycles.
- Exhaustive sweep: byte increments 0→255 every cycle with in_valid = 1.
  - Required: each output equals the reference decimal conversion, 4 edges late, with out_valid continuously 1.
  - Wrap from 255 to 0 must give 12'h255 followed by 12'h000.
- Valid gating: toggle in_valid 1,0,1,1,0 with arbitrary bytes. Required: out_valid reproduces 1,0,1,1,0 delayed by 4 edges, and the BCD values in valid cycles are correct.
- Reset mid-stream: stream 50, 51, 52; assert rst one cycle after sampling 52, then release. Required: none of 50–52 is emitted with out_valid = 1 after reset. The next valid input, 77, yields BCD = 12'h077.
